// File: rtl/out_drain_fifo_if.sv
// out_drain_fifo_if: word stream into the drain FIFO and consumer handshake out of it.
//   dataoutvx3 / dataoutx3 : x3-stage output valid and data (no back-pressure)
//   out_valid / out_data   : head entry presented to the consumer
//   out_ready              : consumer accepts the head entry this cycle
// modport master : the FIFO side (takes the stream, drives the consumer channel)
// modport slave  : the environment (drives the stream, consumes the head entry)
interface out_drain_fifo_if #(
    parameter int DATA_W = 16
);
    logic              dataoutvx3;
    logic [DATA_W-1:0] dataoutx3;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        input  dataoutvx3, dataoutx3, out_ready,
        output out_valid, out_data
    );

    modport slave (
        output dataoutvx3, dataoutx3, out_ready,
        input  out_valid, out_data
    );
endinterface

// File: rtl/out_drain_fifo.sv
// out_drain_fifo: circular FIFO behind the outputs register. The pipeline cannot
// stall, so an incoming word is either stored or dropped. A drop sets a sticky
// overflow flag and bumps a saturating counter.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   bus (master)  : dataoutvx3/dataoutx3 in, out_valid/out_data/out_ready to consumer
//   fill_level    : occupied entries (0..DEPTH)
//   almost_full   : fill_level >= AF_LEVEL
//   overflow      : sticky, at least one word dropped since the last clear
//   drop_count    : dropped words, saturates at all-ones
//   clr_overflow  : clears overflow and drop_count
module out_drain_fifo #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int CNT_W    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    out_drain_fifo_if.master         bus,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     clr_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef logic [DATA_W-1:0] t_data;

    t_data            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    logic             full, pop, push_ok, drop;
    logic [LVL_W-1:0] fill_nxt;

    // Head entry comes straight from storage; no bypass from the write port,
    // so a fresh word becomes visible one cycle after it is pushed. Gating with
    // out_valid keeps out_data at zero while empty (storage is never cleared).
    assign bus.out_valid = (fill_level != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

    assign full    = (fill_level == LVL_W'(DEPTH));
    assign pop     = bus.out_valid & bus.out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_ok = bus.dataoutvx3 & (~full | pop);
    assign drop    = bus.dataoutvx3 & full & ~pop;

    always_comb begin
        fill_nxt = fill_level;
        if (push_ok && !pop)
            fill_nxt = fill_level + LVL_W'(1);
        else if (pop && !push_ok)
            fill_nxt = fill_level - LVL_W'(1);
    end

    // Storage has no reset; words written during reset are unreachable
    // because the pointers are cleared.
    always_ff @(posedge clock) begin
        if (!reset && push_ok)
            mem[wr_ptr] <= bus.dataoutx3;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill_level  <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fill_level  <= fill_nxt;
            almost_full <= (fill_nxt >= LVL_W'(AF_LEVEL));

            // Clear wins over a same-cycle drop for the flag, but that drop
            // is still counted.
            if (clr_overflow) begin
                overflow   <= 1'b0;
                drop_count <= drop ? CNT_W'(1) : '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_out_drain_fifo.sv
module tb_out_drain_fifo;
    logic        clock = 1'b0;
    logic        reset;
    logic        clr_overflow;
    logic [3:0]  fill_level;
    logic        almost_full;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    out_drain_fifo_if #(.DATA_W(16)) bus ();

    out_drain_fifo #(.DATA_W(16), .DEPTH(8), .AF_LEVEL(6), .CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .fill_level   (fill_level),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clr_overflow (clr_overflow)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; clr_overflow = 1'b0;
        bus.dataoutvx3 = 1'b0; bus.dataoutx3 = '0; bus.out_ready = 1'b0;
        tick(); tick();
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_count), 0);
        reset = 1'b0;

        // Three pushes, consumer not ready.
        chk("pre_push_valid", 32'(bus.out_valid), 0);
        bus.dataoutvx3 = 1'b1; bus.dataoutx3 = 16'h1111;
        tick();
        chk("lat1_valid", 32'(bus.out_valid), 1);
        chk("lat1_data", 32'(bus.out_data), 32'h1111);
        bus.dataoutx3 = 16'h2222; tick();
        bus.dataoutx3 = 16'h3333; tick();
        bus.dataoutvx3 = 1'b0;
        chk("three_fill", 32'(fill_level), 3);
        chk("three_head", 32'(bus.out_data), 32'h1111);
        tick();
        chk("hold_head", 32'(bus.out_data), 32'h1111);

        // Drain them.
        bus.out_ready = 1'b1;
        chk("drain0", 32'(bus.out_data), 32'h1111); tick();
        chk("drain1", 32'(bus.out_data), 32'h2222); tick();
        chk("drain2", 32'(bus.out_data), 32'h3333); tick();
        chk("drained_valid", 32'(bus.out_valid), 0);
        chk("drained_fill", 32'(fill_level), 0);
        bus.out_ready = 1'b0;

        // Ten pushes into eight entries.
        for (int i = 0; i < 10; i++) begin
            bus.dataoutvx3 = 1'b1; bus.dataoutx3 = 16'(i);
            tick();
            chk($sformatf("af_after_%0d", i + 1), 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
        end
        bus.dataoutvx3 = 1'b0;
        chk("ovf_fill", 32'(fill_level), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drops", 32'(drop_count), 2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_drain_%0d", i), 32'(bus.out_data), 32'(i));
            tick();
        end
        chk("ovf_empty", 32'(bus.out_valid), 0);
        chk("ovf_empty_af", 32'(almost_full), 0);
        bus.out_ready = 1'b0;

        // Full with simultaneous push and pop across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            bus.dataoutvx3 = 1'b1; bus.dataoutx3 = 16'h0100 + 16'(i);
            tick();
        end
        chk("wrap_full", 32'(fill_level), 8);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.dataoutx3 = 16'h0108 + 16'(k);
            chk($sformatf("wrap_head_%0d", k), 32'(bus.out_data), 32'h0100 + 32'(k));
            tick();
            chk($sformatf("wrap_fill_%0d", k), 32'(fill_level), 8);
        end
        chk("wrap_nodrop", 32'(drop_count), 2);
        bus.dataoutvx3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wrap_tail_%0d", i), 32'(bus.out_data), 32'h0114 + 32'(i));
            tick();
        end
        chk("wrap_empty", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // Clear, then saturate the drop counter.
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_count), 0);
        bus.dataoutvx3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.dataoutx3 = 16'h0200 + 16'(i);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 252) chk("drops_253", 32'(drop_count), 253);
        end
        chk("sat_drop", 32'(drop_count), 255);
        chk("sat_ovf", 32'(overflow), 1);
        chk("sat_fill", 32'(fill_level), 8);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        chk("clr_drop_ovf", 32'(overflow), 0);
        chk("clr_drop_cnt", 32'(drop_count), 1);
        tick();
        bus.dataoutvx3 = 1'b0;
        chk("redrop_cnt", 32'(drop_count), 2);
        chk("redrop_ovf", 32'(overflow), 1);

        // Down to five entries, then reset with a push and a pop pending.
        bus.out_ready = 1'b1;
        chk("keep_head", 32'(bus.out_data), 32'h0200);
        tick(); tick(); tick();
        chk("five_fill", 32'(fill_level), 5);
        chk("five_head", 32'(bus.out_data), 32'h0203);
        reset = 1'b1; bus.dataoutvx3 = 1'b1; bus.dataoutx3 = 16'hBEEF;
        tick();
        reset = 1'b0; bus.dataoutvx3 = 1'b0; bus.out_ready = 1'b0;
        chk("mid_rst_fill", 32'(fill_level), 0);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_drop", 32'(drop_count), 0);
        chk("mid_rst_af", 32'(almost_full), 0);
        bus.dataoutvx3 = 1'b1; bus.dataoutx3 = 16'hABCD;
        tick();
        bus.dataoutvx3 = 1'b0;
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_data", 32'(bus.out_data), 32'hABCD);
        chk("post_rst_fill", 32'(fill_level), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/out_drain_fifo.md
Name: out_drain_fifo

Overview:
- Downstream neighbour of the outputs register.
- Consumes the x3-stage output word (dataoutvx3/dataoutx3) and buffers it in a circular FIFO.
- Presents buffered words to the external consumer over a valid/ready handshake.
- The pipeline cannot stall, so words are never back-pressured: they are stored, or dropped and accounted for when the FIFO is full.

Parameters:
- DATA_W, 16, width of t_data; data ports are t_data.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- AF_LEVEL, 6, fill level at or above which almost_full asserts; 1..DEPTH.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- dataoutvx3  in  1  x3-stage output valid; a word is presented this cycle.
- dataoutx3  in  DATA_W  x3-stage output data (t_data).
- out_valid  out  1  head entry available to the consumer.
- out_data  out  DATA_W  head entry data.
- out_ready  in  1  consumer accepts the head entry this cycle.
- fill_level  out  $clog2(DEPTH)+1  number of occupied entries.
- almost_full  out  1  fill_level >= AF_LEVEL.
- overflow  out  1  sticky flag: at least one word dropped since last clear.
- drop_count  out  CNT_W  count of dropped words; saturates at all-ones.
- clr_overflow  in  1  clears overflow and drop_count.

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clock):
  - rd_ptr = wr_ptr = 0, fill_level = 0.
  - out_valid = 0, out_data = 0, almost_full = 0, overflow = 0, drop_count = 0.
  - Storage contents need not be cleared.
  - Reset has priority over every other event, including a push/pop in the same cycle.
  - Reset mid-operation discards all buffered words; they are not counted as drops.
- Push: a push is attempted when dataoutvx3 = 1. It is accepted when fill_level < DEPTH, or when fill_level = DEPTH and a pop occurs in the same cycle.
- Accepted push: write dataoutx3 at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: pop = out_valid & out_ready. On a pop, rd_ptr increments modulo DEPTH.
- out_valid = (fill_level != 0).
- out_data = mem[rd_ptr], driven combinationally from storage, registered contents only.
- No bypass: a word pushed into an empty FIFO appears on out_valid/out_data the cycle after the push (latency 1 cycle from dataoutvx3 to out_valid).
- fill_level update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Empty, pop attempted: not possible, since out_valid = 0. out_ready is ignored when empty.
- Full with push, no pop: the word is dropped and storage is unchanged.
  - overflow <= 1.
  - drop_count <= drop_count + 1, unless already all-ones (saturate, no wrap).
- Full with push and pop simultaneously: the push is accepted, no drop, fill_level stays DEPTH.
- clr_overflow = 1: overflow <= 0 and drop_count <= 0. If a drop occurs in the same cycle, the clear wins for overflow, and drop_count <= 1.
- almost_full and fill_level are registered state, consistent with the pointers after each edge.
- Pointers are $clog2(DEPTH) bits and wrap naturally. fill_level distinguishes full from empty.
- out_data is held stable while out_valid = 1 and out_ready = 0.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles with out_ready = 0 → out_valid rises the cycle after the first push; fill_level = 3; out_data = 0x1111 held stable.
- Raise out_ready = 1 with no pushes → out_data sequence 0x1111, 0x2222, 0x3333 on three cycles; then out_valid = 0 and fill_level = 0.
- Push 10 words 0x0000..0x0009 with out_ready = 0 (DEPTH = 8):
  - almost_full asserts after the 6th push.
  - fill_level = 8; overflow = 1; drop_count = 2.
  - Drained data is exactly 0x0000..0x0007.
- Fill to 8, then hold dataoutvx3 = 1 and out_ready = 1 for 20 cycles with incrementing data → no drops, fill_level stays 8, output order matches input order across pointer wrap.
- Force 300 drops → drop_count saturates at 255. Then pulse clr_overflow together with one more drop → overflow = 0, drop_count = 1.
- With fill_level = 5, assert reset together with a push and a pop → next cycle fill_level = 0, out_valid = 0, overflow = 0.
